// File: rtl/hs32_pkg.sv
// Shared HS32 decode definitions: opcodes, ALU ops, control words and the decoded record.
package hs32_pkg;

  localparam int unsigned OPC_W       = 4;
  localparam int unsigned ALUOP_W     = 3;
  localparam int unsigned CTL_K_W     = 8;
  localparam int unsigned DEC_IMM_W   = 16;
  localparam int unsigned DEC_REG_W   = 4;
  localparam int unsigned DEC_SHIFT_W = 5;
  localparam int unsigned DEC_CTL_W   = 16;

  localparam logic [OPC_W-1:0] HS32_LDRI = 4'h1;
  localparam logic [OPC_W-1:0] HS32_LDR  = 4'h2;
  localparam logic [OPC_W-1:0] HS32_LDRA = 4'h3;
  localparam logic [OPC_W-1:0] HS32_STRI = 4'h4;
  localparam logic [OPC_W-1:0] HS32_STR  = 4'h5;
  localparam logic [OPC_W-1:0] HS32_STRA = 4'h6;

  localparam logic [ALUOP_W-1:0] HS32_ADD = 3'd1;
  localparam logic [ALUOP_W-1:0] HS32_SUB = 3'd2;
  localparam logic [ALUOP_W-1:0] HS32_AND = 3'd3;
  localparam logic [ALUOP_W-1:0] HS32_OR  = 3'd4;

  // bit 0 mem access, bit 2 address uses Rn, bit 3 immediate, bit 4 load, bit 5 store
  localparam logic [CTL_K_W-1:0] CTL_NOP  = 8'h00;
  localparam logic [CTL_K_W-1:0] CTL_LDRI = 8'h19;
  localparam logic [CTL_K_W-1:0] CTL_LDR  = 8'h11;
  localparam logic [CTL_K_W-1:0] CTL_LDRA = 8'h15;
  localparam logic [CTL_K_W-1:0] CTL_STRI = 8'h29;
  localparam logic [CTL_K_W-1:0] CTL_STR  = 8'h21;
  localparam logic [CTL_K_W-1:0] CTL_STRA = 8'h25;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [ALUOP_W-1:0]     aluop;
    logic [DEC_SHIFT_W-1:0] shift;
    logic [DEC_IMM_W-1:0]   imm;
    logic [DEC_REG_W-1:0]   regdst;
    logic [DEC_REG_W-1:0]   regsrc;
    logic [DEC_REG_W-1:0]   regopd;
    logic [DEC_CTL_W-1:0]   ctlsig;
  } dec_fields_t;

  typedef struct packed {
    dec_fields_t f;
    logic        fault;
  } dec_t;

  function automatic logic [DEC_CTL_W-1:0] ctl_word(input logic [CTL_K_W-1:0] c);
    return DEC_CTL_W'(c);
  endfunction

  function automatic logic opc_defined(input logic [OPC_W-1:0] op);
    return op inside {HS32_LDRI, HS32_LDR, HS32_LDRA, HS32_STRI, HS32_STR, HS32_STRA};
  endfunction

endpackage

// File: rtl/hs32_skid_buf.sv
// Generic two-entry valid/ready skid buffer; M drives the output, S absorbs one extra entry.
module hs32_skid_buf
  import hs32_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         accept;
  logic         drain;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SB_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Flush wins over accept and drain and clears stored entries.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    accept  = in_valid && ready_q;
    drain   = valid_q && out_ready;
    if (flush) begin
      state_d = SB_EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (accept) begin
            m_d     = in_data;
            state_d = SB_ONE;
          end
        end
        SB_ONE: begin
          if (accept && drain) begin
            m_d = in_data;
          end else if (accept) begin
            s_d     = in_data;
            state_d = SB_FULL;
          end else if (drain) begin
            state_d = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (drain) begin
            m_d     = s_q;
            state_d = SB_ONE;
          end
        end
        default: state_d = SB_EMPTY;
      endcase
    end
    ready_d = (state_d != SB_FULL);
    valid_d = (state_d != SB_EMPTY);
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = m_q;

endmodule

// File: rtl/hs32_decode_pipe.sv
// HS32 registered decode stage with a two-entry skid buffer toward execute.
// Define HS32_DEC_FAULT_EN to add the per-entry undefined-opcode fault output.
module hs32_decode_pipe
  import hs32_pkg::*;
#(
  parameter int unsigned IMM_W   = DEC_IMM_W,
  parameter int unsigned REG_W   = DEC_REG_W,
  parameter int unsigned SHIFT_W = DEC_SHIFT_W,
  parameter int unsigned CTL_W   = DEC_CTL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instd,
  input  logic               ackd,
  output logic               reqd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         aluop,
  output logic [SHIFT_W-1:0] shift,
  output logic [IMM_W-1:0]   imm,
  output logic [REG_W-1:0]   regdst,
  output logic [REG_W-1:0]   regsrc,
  output logic [REG_W-1:0]   regopd,
  output logic [CTL_W-1:0]   ctlsig
`ifdef HS32_DEC_FAULT_EN
  ,
  output logic               fault
`endif
);

  logic [OPC_W-1:0] opc;
  dec_fields_t      fields_d;
  dec_fields_t      fields_q;
  logic             unused_rsvd;

  assign opc         = instd[31:28];
  assign unused_rsvd = ^instd[27:24];

  // Field extraction; undefined opcodes leave everything zero with a NOP control word.
  always_comb begin
    fields_d        = '0;
    fields_d.ctlsig = ctl_word(CTL_NOP);
    if (opc_defined(opc)) begin
      fields_d.aluop  = HS32_ADD;
      fields_d.regdst = DEC_REG_W'(instd[23:20]);
      fields_d.regsrc = DEC_REG_W'(instd[19:16]);
    end
    case (opc)
      HS32_LDRI: begin
        fields_d.imm    = DEC_IMM_W'(instd[IMM_W-1:0]);
        fields_d.ctlsig = ctl_word(CTL_LDRI);
      end
      HS32_LDR: fields_d.ctlsig = ctl_word(CTL_LDR);
      HS32_LDRA: begin
        fields_d.shift  = DEC_SHIFT_W'(instd[11:7]);
        fields_d.regopd = DEC_REG_W'(instd[15:12]);
        fields_d.ctlsig = ctl_word(CTL_LDRA);
      end
      HS32_STRI: begin
        fields_d.imm    = DEC_IMM_W'(instd[IMM_W-1:0]);
        fields_d.ctlsig = ctl_word(CTL_STRI);
      end
      HS32_STR: fields_d.ctlsig = ctl_word(CTL_STR);
      HS32_STRA: begin
        fields_d.shift  = DEC_SHIFT_W'(instd[11:7]);
        fields_d.regopd = DEC_REG_W'(instd[15:12]);
        fields_d.ctlsig = ctl_word(CTL_STRA);
      end
      default: ;
    endcase
  end

`ifdef HS32_DEC_FAULT_EN
  dec_t pay_in, pay_out;
  assign pay_in   = '{f: fields_d, fault: !opc_defined(opc)};
  assign fields_q = pay_out.f;
  assign fault    = pay_out.fault;
`else
  dec_fields_t pay_in, pay_out;
  assign pay_in   = fields_d;
  assign fields_q = pay_out;
`endif

  hs32_skid_buf #(
    .W($bits(pay_in))
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (ackd),
    .in_ready (reqd),
    .in_data  (pay_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pay_out)
  );

  assign aluop  = fields_q.aluop;
  assign shift  = SHIFT_W'(fields_q.shift);
  assign imm    = IMM_W'(fields_q.imm);
  assign regdst = REG_W'(fields_q.regdst);
  assign regsrc = REG_W'(fields_q.regsrc);
  assign regopd = REG_W'(fields_q.regopd);
  assign ctlsig = CTL_W'(fields_q.ctlsig);

endmodule

// File: doc/hs32_decode_pipe.md
# hs32_decode_pipe

Registered, parametrised decode stage between fetch and execute of the HS32 core. It accepts 32-bit instruction words from fetch under a valid/ready handshake and splits them into ALU op, shift, immediate, register indices and control word. Results are buffered in a two-entry skid buffer, so fetch sees a registered ready and execute may stall without losing an instruction. It adds flush support, full load/store coverage, and optional undefined-opcode fault reporting.

## Interface

Parameters:
- `IMM_W`, default 16: immediate width, taken from `instd[IMM_W-1:0]`.
- `REG_W`, default 4: register index width; fields are fixed at [23:20], [19:16] and [15:12] for `REG_W`=4.
- `SHIFT_W`, default 5: shift amount width, taken from `instd[11:7]`.
- `CTL_W`, default 16: control word width; package constants are zero-extended to `CTL_W`.

Ports:
- `clk`, input, 1: core clock.
- `reset`, input, 1: **synchronous, active-low** reset.
- `instd`, input, 32: instruction word from fetch.
- `ackd`, input, 1: fetch valid; `instd` is meaningful.
- `reqd`, output, 1: decode ready; a transfer occurs when `ackd && reqd` at a rising edge.
- `flush`, input, 1: discard all buffered instructions (branch/exception).
- `out_valid`, output, 1: decoded fields valid.
- `out_ready`, input, 1: execute accepts; a transfer occurs when `out_valid && out_ready`.
- `aluop`, output, 3: ALU operation.
- `shift`, output, `SHIFT_W`: shift amount.
- `imm`, output, `IMM_W`: immediate.
- `regdst`, `regsrc`, `regopd`, output, `REG_W` each: Rd, Rm, Rn.
- `ctlsig`, output, `CTL_W`: control signals.
- `fault`, output, 1: undefined opcode. Present only with `HS32_DEC_FAULT_EN`.

## Operation

- Opcode field `instd[31:28]` is combinationally decoded into a packed record, then registered.
- LDRI: ADD, imm=IMM, Rd, Rm, Rn=0, shift=0, ctl=`CTL_LDRI`.
- LDR: ADD, imm=0, Rd, Rm, Rn=0, shift=0, ctl=`CTL_LDR`.
- LDRA: ADD, shift=SHIFT, imm=0, Rd, Rm, Rn, ctl=`CTL_LDRA`.
- STRI: ADD, imm=IMM (the immediate is carried), Rd, Rm, Rn=0, ctl=`CTL_STRI`.
- STR: ADD, imm=0, Rd, Rm, Rn=0, ctl=`CTL_STR`.
- STRA: ADD, shift=SHIFT, imm=0, Rd, Rm, Rn, ctl=`CTL_STRA`.
- Any other opcode: all fields 0 and ctl=`CTL_NOP`. With `HS32_DEC_FAULT_EN`, `fault`=1 for that entry.
- Buffer: main register M drives the outputs; skid register S holds one extra entry.
- States are EMPTY, ONE (M valid) and FULL (M and S valid).
  - EMPTY + accept → ONE.
  - ONE + accept + no drain → FULL.
  - ONE + drain + no accept → EMPTY.
  - ONE + accept + drain → ONE, with M loaded with the new entry.
  - FULL + drain → ONE, with S moved to M.
  - FULL never accepts, because `reqd`=0.
- Order is strictly FIFO; no instruction is duplicated or dropped.
- `flush`=1 → next state EMPTY, and any accept that cycle is discarded. `flush` has priority over accept and drain.

## Timing

- Reset (`reset`=0 at an edge) clears both entries. While in reset: `out_valid`=0, `reqd`=0, all data outputs 0, `fault`=0.
- First edge with `reset`=1: `reqd` becomes 1.
- `reqd` is registered and equals "S empty". It never depends combinationally on `out_ready`.
- Latency: an instruction accepted at edge N appears with `out_valid`=1 after edge N (visible in cycle N+1) when the buffer was EMPTY, or when it was ONE and drained at edge N.
- Throughput: one instruction per cycle while `out_ready`=1.
- Outputs are stable while `out_valid && !out_ready`.
- Data outputs keep their last value when `out_valid`=0; they are not required to be zero.
- A `reset` asserted mid-stream takes effect at the same edge and overrides `flush`, accept and drain.

## Configuration

- `HS32_DEC_FAULT_EN` defined:
  - `fault` port exists and is stored per buffer entry (M and S).
  - Undefined opcodes decode as NOP with `fault`=1.
  - `fault` travels with its entry and is cleared by reset and flush.
- Undefined:
  - No `fault` port or storage.
  - Undefined opcodes pass silently as NOP.

## Structure

- Shared package `hs32_pkg`:
  - opcode constants (`HS32_LDRI`…`HS32_STRA`);
  - ALU op constants (`HS32_ADD`…);
  - `CTL_*` control words, including `CTL_NOP`;
  - packed `dec_t` record: aluop, shift, imm, regdst, regsrc, regopd, ctlsig, fault.
- Sub-module `hs32_skid_buf`: generic two-entry valid/ready skid buffer parametrised on payload width. The decoder instantiates it on `dec_t`.

## Test plan

- Streaming: LDRI with Rd=3, Rm=4, imm=0x1234, `out_ready`=1.
  - Expect `out_valid` one cycle later with aluop=ADD, regdst=3, regsrc=4, regopd=0, imm=0x1234, ctl=`CTL_LDRI`.
  - Then 8 back-to-back instructions leave at one per cycle, in order.
- Shift decode: LDRA with shift=7, Rn=5 → shift=7, regopd=5, imm=0. STRI with imm=0xBEEF → imm=0xBEEF, ctl=`CTL_STRI`.
- Backpressure: hold `out_ready`=0 and offer 3 instructions.
  - Two are accepted; `reqd`=0 after the second.
  - The first stays stable on the outputs.
  - Release `out_ready` → all three exit in order, with no loss or duplicate.
- Flush: in the FULL state, assert `flush` together with `ackd`.
  - Next cycle: `out_valid`=0, `reqd`=1.
  - The flushed-cycle instruction never appears.
- Reset mid-stream: drive `reset`=0 while FULL.
  - Next cycle: `out_valid`=0, `reqd`=0, data outputs 0.
  - After `reset`=1: `reqd`=1 and streaming resumes normally.
- Undefined opcode, with `HS32_DEC_FAULT_EN` defined: expect ctl=`CTL_NOP`, `fault`=1, and `fault`=0 on the next valid opcode. Without the macro: NOP output only.
